// File: rtl/corescore_rr_pick.sv
// Round-robin picker: returns the first requester found scanning upward from
// (last+1) with wrap-around, plus a flag telling whether anyone requested.
module corescore_rr_pick #(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int cand;

  // Walk the scan order backwards so the nearest requester after 'last' wins.
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    cand  = 0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      cand = int'(i_last) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (i_req[cand]) o_idx = IDX_W'(cand);
    end
  end

endmodule

// File: rtl/corescore_emit_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC byte streams into one
// downstream stream, holding the grant until tlast or the MAX_BEATS cap.
module corescore_emit_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int MAX_BEATS = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [8*NUM_SRC-1:0] i_tdata,
  input  logic [NUM_SRC-1:0]   i_tlast,
  input  logic [NUM_SRC-1:0]   i_tvalid,
  output logic [NUM_SRC-1:0]   o_tready,
  output logic [7:0]           o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 i_tready,
  output logic [NUM_SRC-1:0]   o_grant,
  output logic                 o_overrun
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CNT_W-1:0] CAP_M1 = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_SRC - 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overrun_q, overrun_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               locked;
  logic               sel_valid, sel_last, beat;
  logic [7:0]         sel_data;

  corescore_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req  (i_tvalid),
    .i_last (last_q),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  // Zero-latency pass-through of the granted source; everything is forced
  // quiet while idle so no source can see a stray ready.
  always_comb begin
    locked    = (state_q == ST_LOCKED);
    sel_data  = i_tdata[8*gidx_q +: 8];
    sel_valid = i_tvalid[gidx_q];
    sel_last  = i_tlast[gidx_q];
    beat      = locked & sel_valid & i_tready;
    o_tdata   = locked ? sel_data : 8'h00;
    o_tvalid  = locked & sel_valid;
    o_tlast   = locked & sel_last;
    o_tready  = grant_q & {NUM_SRC{i_tready}};
    o_grant   = grant_q;
    o_overrun = overrun_q;
  end

  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d           = ST_LOCKED;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          cnt_d             = '0;
        end
      end
      ST_LOCKED: begin
        if (beat) begin
          // Saturate so the count never wraps when the cap is disabled.
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          if (sel_last || ((MAX_BEATS > 0) && (cnt_q == CAP_M1))) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = gidx_q;
            if (!sel_last) overrun_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      gidx_q    <= '0;
      last_q    <= LAST_RST;
      grant_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_corescore_emit_arbiter.sv
// Bench for corescore_emit_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference of the arbiter.
module tb_corescore_emit_arbiter;

  localparam int NSRC = 3;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [8*NSRC-1:0] tdataIn = '0;
  logic [NSRC-1:0]   tlastIn = '0;
  logic [NSRC-1:0]   tvalidIn = '0;
  logic              treadyIn = 1'b0;
  logic [NSRC-1:0]   treadyOut;
  logic [7:0]        tdataOut;
  logic              tlastOut;
  logic              tvalidOut;
  logic [NSRC-1:0]   grant;
  logic              overrun;

  int checks = 0;
  int failures = 0;

  // Each source holds a queue of pending beats as {tlast, data}.
  logic [8:0] srcQ[NSRC][$];
  logic [7:0] beatLog[$];

  // Reference view: owner is -1 when no packet is being forwarded.
  int mOwner = -1;
  int mLast  = NSRC - 1;
  int mCnt   = 0;
  bit mOvr   = 1'b0;

  logic [NSRC-1:0] obsGrant, obsReady;
  logic [7:0]      obsData;
  logic            obsLast, obsValid, obsOvr;

  logic [NSRC-1:0] t2Exp[13] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd0,
                                 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd0};

  always #5 clk = ~clk;

  corescore_emit_arbiter #(
    .NUM_SRC   (NSRC),
    .MAX_BEATS (MAXB)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_tdata   (tdataIn),
    .i_tlast   (tlastIn),
    .i_tvalid  (tvalidIn),
    .o_tready  (treadyOut),
    .o_tdata   (tdataOut),
    .o_tlast   (tlastOut),
    .o_tvalid  (tvalidOut),
    .i_tready  (treadyIn),
    .o_grant   (grant),
    .o_overrun (overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic loadPacket(input int src, input int len, input logic [7:0] first);
    for (int i = 0; i < len; i++)
      srcQ[src].push_back({(i == len - 1), first + 8'(i)});
  endtask

  // One clock cycle: drive sources, compare against the reference, then let
  // sources retire accepted beats and advance the reference to the next cycle.
  task automatic applyStimulus(input logic [NSRC-1:0] mask, input logic rdy, input logic rstIn);
    logic [NSRC-1:0] expGrant, expReady;
    logic [7:0]      expData;
    logic            expLast, expValid;
    int              found;
    @(negedge clk);
    rst = rstIn;
    treadyIn = rdy;
    for (int k = 0; k < NSRC; k++) begin
      if (mask[k] && srcQ[k].size() > 0) begin
        tvalidIn[k] = 1'b1;
        tdataIn[8*k +: 8] = srcQ[k][0][7:0];
        tlastIn[k] = srcQ[k][0][8];
      end else begin
        tvalidIn[k] = 1'b0;
        tdataIn[8*k +: 8] = 8'($urandom);
        tlastIn[k] = 1'($urandom);
      end
    end
    #1;
    obsGrant = grant;
    obsReady = treadyOut;
    obsData  = tdataOut;
    obsLast  = tlastOut;
    obsValid = tvalidOut;
    obsOvr   = overrun;

    expGrant = '0; expReady = '0; expData = 8'h00; expLast = 1'b0; expValid = 1'b0;
    if (mOwner >= 0) begin
      expGrant[mOwner] = 1'b1;
      expReady[mOwner] = rdy;
      expData  = tdataIn[8*mOwner +: 8];
      expLast  = tlastIn[mOwner];
      expValid = tvalidIn[mOwner];
    end
    checkOutput("ref_grant", obsGrant, expGrant);
    checkOutput("ref_tready", obsReady, expReady);
    checkOutput("ref_tvalid", obsValid, expValid);
    checkOutput("ref_tdata", obsData, expData);
    checkOutput("ref_tlast", obsLast, expLast);
    checkOutput("ref_overrun", obsOvr, mOvr);

    if (obsValid && rdy) beatLog.push_back(obsData);
    for (int k = 0; k < NSRC; k++)
      if (obsReady[k] && tvalidIn[k] && srcQ[k].size() > 0) srcQ[k].delete(0);

    if (rstIn) begin
      mOwner = -1; mLast = NSRC - 1; mCnt = 0; mOvr = 1'b0;
    end else if (mOwner < 0) begin
      found = -1;
      for (int i = 1; i <= NSRC; i++) begin
        int s;
        s = (mLast + i) % NSRC;
        if (found < 0 && tvalidIn[s]) found = s;
      end
      if (found >= 0) begin
        mOwner = found;
        mCnt = 0;
      end
    end else if (tvalidIn[mOwner] && rdy) begin
      mCnt++;
      if (tlastIn[mOwner]) begin
        mLast = mOwner; mOwner = -1;
      end else if (MAXB > 0 && mCnt == MAXB) begin
        mOvr = 1'b1; mLast = mOwner; mOwner = -1;
      end
    end
  endtask

  initial begin
    int pending;

    // Reset state and a simple three-byte packet from source 0.
    applyStimulus('0, 1'b1, 1'b1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("rst_grant", obsGrant, 0);
    checkOutput("rst_overrun", obsOvr, 0);
    loadPacket(0, 3, 8'h41);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t1_req_idle", obsGrant, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b001, 1'b1, 1'b0);
      checkOutput("t1_grant", obsGrant, 3'b001);
      checkOutput("t1_data", obsData, 8'h41 + i);
      checkOutput("t1_last", obsLast, (i == 2));
    end
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t1_released", obsGrant, 0);

    // Two sources with continuous 2-beat packets must alternate.
    applyStimulus('0, 1'b1, 1'b1);
    loadPacket(0, 2, 8'h10); loadPacket(1, 2, 8'h20);
    loadPacket(0, 2, 8'h30); loadPacket(1, 2, 8'h40);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(3'b011, 1'b1, 1'b0);
      checkOutput("t2_alternate", obsGrant, t2Exp[i]);
    end

    // A stalled owner keeps the lock while another source waits.
    applyStimulus('0, 1'b1, 1'b1);
    loadPacket(1, 3, 8'h50); loadPacket(0, 1, 8'h60);
    applyStimulus(3'b010, 1'b1, 1'b0);
    applyStimulus(3'b010, 1'b1, 1'b0);
    checkOutput("t3_first", obsData, 8'h50);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b001, 1'b1, 1'b0);
      checkOutput("t3_hold_grant", obsGrant, 3'b010);
      checkOutput("t3_src0_ready", obsReady[0], 0);
    end
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkOutput("t3_resume", obsData, 8'h51);
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkOutput("t3_tail", obsData, 8'h52);
    for (int i = 0; i < 3; i++) applyStimulus(3'b001, 1'b1, 1'b0);

    // Six-beat packet against a four-beat cap.
    applyStimulus('0, 1'b1, 1'b1);
    loadPacket(0, 6, 8'h70);
    applyStimulus(3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b001, 1'b1, 1'b0);
      checkOutput("t4_beat", obsData, 8'h70 + i);
      checkOutput("t4_no_ovr_yet", obsOvr, 0);
    end
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t4_cut_grant", obsGrant, 0);
    checkOutput("t4_overrun", obsOvr, 1);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t4_rest5", obsData, 8'h74);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t4_rest6", obsData, 8'h75);
    checkOutput("t4_rest6_last", obsLast, 1);
    applyStimulus(3'b001, 1'b1, 1'b0);

    // Reset part-way through a packet while the overrun flag is set.
    loadPacket(0, 5, 8'h90); loadPacket(1, 1, 8'hA0);
    applyStimulus(3'b001, 1'b1, 1'b0);
    applyStimulus(3'b001, 1'b1, 1'b0);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t6_pre_ovr", obsOvr, 1);
    applyStimulus(3'b001, 1'b1, 1'b1);
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkOutput("t6_grant", obsGrant, 0);
    checkOutput("t6_tvalid", obsValid, 0);
    checkOutput("t6_overrun", obsOvr, 0);
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkOutput("t6_regrant", obsGrant, 3'b001);
    for (int i = 0; i < 6; i++) applyStimulus(3'b011, 1'b1, 1'b0);

    // Downstream ready toggling every cycle through a 4-beat packet.
    applyStimulus('0, 1'b1, 1'b1);
    loadPacket(2, 4, 8'h80);
    beatLog.delete();
    for (int i = 0; i < 12; i++) applyStimulus(3'b100, 1'(i % 2), 1'b0);
    checkOutput("t5_count", beatLog.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("t5_order", (i < beatLog.size()) ? {24'h0, beatLog[i]} : 32'hDEAD, 8'h80 + i);

    // Randomized traffic, occasional resets, then a bounded drain.
    applyStimulus('0, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < NSRC; k++)
        if (srcQ[k].size() < 3 && $urandom_range(0, 3) == 0)
          loadPacket(k, $urandom_range(1, 7), 8'($urandom));
      applyStimulus(NSRC'($urandom), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 199) == 0));
    end
    pending = 0;
    for (int k = 0; k < NSRC; k++) pending += srcQ[k].size();
    for (int cyc = 0; cyc < 400 && pending > 0; cyc++) begin
      applyStimulus('1, 1'b1, 1'b0);
      pending = 0;
      for (int k = 0; k < NSRC; k++) pending += srcQ[k].size();
    end
    checkOutput("drain_empty", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
